// File: rtl/seq_calculator.sv
// Sequential add/sub/mul/div unit with a valid/ready handshake on both sides.
// Add, sub and mul finish in one cycle; division runs a restoring loop, one quotient bit per cycle.
module seq_calculator #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           mode,
   input  logic                 signed_operation,
   input  logic [WIDTH-1:0]     operand_a,
   input  logic [WIDTH-1:0]     operand_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   result,
   output logic [WIDTH-1:0]     remainder,
   output logic                 overflow,
   output logic                 divide_by_zero
);

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   state_t             state;
   logic [CW-1:0]      step_count;
   logic [WIDTH-1:0]   div_rem;
   logic [WIDTH-1:0]   div_quo;
   logic [WIDTH-1:0]   div_divisor;
   logic               div_signed;
   logic               neg_quo;
   logic               neg_rem;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] arith_result;
   logic               arith_overflow;

   logic [WIDTH:0]     trial;
   logic [WIDTH:0]     diff;
   logic               quo_bit;
   logic [WIDTH-1:0]   rem_next;
   logic [WIDTH-1:0]   quo_next;
   logic [2*WIDTH-1:0] quo_ext;
   logic [2*WIDTH-1:0] div_result;
   logic [WIDTH-1:0]   div_remainder;
   logic               div_overflow;

   // Operands widened to 2*WIDTH make add, sub and mul exact; overflow is then a range check on the upper half.
   always_comb begin
      a_neg = signed_operation & operand_a[WIDTH-1];
      b_neg = signed_operation & operand_b[WIDTH-1];
      mag_a = a_neg ? -operand_a : operand_a;
      mag_b = b_neg ? -operand_b : operand_b;
      ext_a = {{WIDTH{a_neg}}, operand_a};
      ext_b = {{WIDTH{b_neg}}, operand_b};
      case (mode)
         2'b00:   arith_result = ext_a + ext_b;
         2'b01:   arith_result = ext_a - ext_b;
         2'b10:   arith_result = ext_a * ext_b;
         default: arith_result = '0;
      endcase
      if (signed_operation)
         arith_overflow = ~((&arith_result[2*WIDTH-1:WIDTH-1]) | ~(|arith_result[2*WIDTH-1:WIDTH-1]));
      else
         arith_overflow = |arith_result[2*WIDTH-1:WIDTH];
   end

   // One restoring step: the dividend shifts out of div_quo as quotient bits shift in; diff[WIDTH] is the borrow.
   always_comb begin
      trial         = {div_rem, div_quo[WIDTH-1]};
      diff          = trial - {1'b0, div_divisor};
      quo_bit       = ~diff[WIDTH];
      rem_next      = quo_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      quo_next      = {div_quo[WIDTH-2:0], quo_bit};
      quo_ext       = {{WIDTH{1'b0}}, quo_next};
      div_result    = neg_quo ? -quo_ext : quo_ext;
      div_remainder = neg_rem ? -rem_next : rem_next;
      div_overflow  = div_signed & ~neg_quo & quo_next[WIDTH-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         in_ready       <= 1'b1;
         out_valid      <= 1'b0;
         result         <= '0;
         remainder      <= '0;
         overflow       <= 1'b0;
         divide_by_zero <= 1'b0;
         step_count     <= '0;
         div_rem        <= '0;
         div_quo        <= '0;
         div_divisor    <= '0;
         div_signed     <= 1'b0;
         neg_quo        <= 1'b0;
         neg_rem        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (mode == 2'b11 && operand_b != '0) begin
                     div_rem     <= '0;
                     div_quo     <= mag_a;
                     div_divisor <= mag_b;
                     div_signed  <= signed_operation;
                     neg_quo     <= a_neg ^ b_neg;
                     neg_rem     <= a_neg;
                     step_count  <= '0;
                     in_ready    <= 1'b0;
                     state       <= DIV;
                  end else begin
                     if (mode == 2'b11) begin
                        result         <= '1;
                        remainder      <= operand_a;
                        overflow       <= 1'b0;
                        divide_by_zero <= 1'b1;
                     end else begin
                        result         <= arith_result;
                        remainder      <= '0;
                        overflow       <= arith_overflow;
                        divide_by_zero <= 1'b0;
                     end
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end
               end
            end
            DIV: begin
               div_rem    <= rem_next;
               div_quo    <= quo_next;
               step_count <= step_count + 1'b1;
               if (step_count == LAST_STEP) begin
                  result         <= div_result;
                  remainder      <= div_remainder;
                  overflow       <= div_overflow;
                  divide_by_zero <= 1'b0;
                  out_valid      <= 1'b1;
                  state          <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/seq_calculator.md
SEQ_CALCULATOR -- requirements
Module: seq_calculator

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  request present on the operand/mode inputs.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 mode  input  2  00 add, 01 sub, 10 mul, 11 div.
REQ-007 signed_operation  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 operand_a  input  WIDTH  first operand (dividend for div).
REQ-009 operand_b  input  WIDTH  second operand (divisor for div).
REQ-010 out_valid  output  1  result, remainder and flags valid.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 result  output  2*WIDTH  exact result; sign-extended when signed, zero-extended otherwise.
REQ-013 remainder  output  WIDTH  division remainder; 0 for non-div modes.
REQ-014 overflow  output  1  exact result not representable in WIDTH bits of the selected signedness.
REQ-015 divide_by_zero  output  1  div request with operand_b == 0.

Function
REQ-016 FSM states: IDLE, DIV, DONE. in_ready = 1 only in IDLE.
REQ-017 Acceptance: in_valid && in_ready at a rising edge; all inputs are captured at that edge and later input changes have no effect.
REQ-018 Add, sub, mul, and div with operand_b == 0: IDLE -> DONE at the acceptance edge, so out_valid is high in the next cycle (latency 1).
REQ-019 Div with operand_b != 0: IDLE -> DIV. One restoring quotient bit per cycle on operand magnitudes; exactly WIDTH cycles in DIV, then -> DONE. out_valid rises WIDTH+1 edges after acceptance.
REQ-020 DONE: out_valid = 1; result, remainder and flags are held stable. On out_valid && out_ready -> IDLE. out_valid drops the following cycle and in_ready rises.
REQ-021 Add/sub: result = exact a+b or a-b in 2*WIDTH bits.
  - Unsigned sub with a < b: result = 2*WIDTH-bit two's complement of the difference, overflow = 1.
REQ-022 Add/sub overflow: signed, result outside [-2^(W-1), 2^(W-1)-1]; unsigned, carry-out (add) or borrow (sub).
REQ-023 Mul: result = full 2*WIDTH-bit product. overflow = 1 iff the product does not fit in WIDTH bits (signed or unsigned per signed_operation).
REQ-024 Div quotient (result) truncates toward zero. Remainder takes the sign of the dividend; |remainder| < |divisor|.
REQ-025 Signed div of most-negative by -1: result = +2^(W-1) in 2*WIDTH bits, remainder = 0, overflow = 1.
REQ-026 Div by zero: result = all ones, remainder = operand_a, divide_by_zero = 1, overflow = 0.
REQ-027 Flags are 0 whenever they do not apply. divide_by_zero is 0 for modes 00, 01 and 10.
REQ-028 in_valid while not IDLE: ignored, with no state change. Requests are never queued.

Reset
REQ-029 When rst = 1 at an edge: state = IDLE, out_valid = 0, result = 0, remainder = 0, overflow = 0, divide_by_zero = 0. in_ready = 1 from the next cycle.
REQ-030 rst overrides any concurrent in_valid or out_ready and aborts an in-progress DIV or DONE.
  - No partial or stale result is ever presented after reset.

Verification
REQ-031 WIDTH=8, unsigned add 200+100 -> result 16'h012C, overflow 1, out_valid exactly 1 cycle after acceptance.
REQ-032 WIDTH=8, signed sub 8'h80-8'h01 -> result 16'hFF7F, overflow 1. Unsigned sub 5-10 -> result 16'hFFFB, overflow 1.
REQ-033 WIDTH=8, signed mul 8'h80*8'h80 -> result 16'h4000, overflow 1. Unsigned mul 15*17 -> result 16'h00FF, overflow 0.
REQ-034 WIDTH=8, unsigned div 200/7 -> result 16'h001C, remainder 8'h04, out_valid 9 edges after acceptance.
  - Signed div -7/2 -> result 16'hFFFD, remainder 8'hFF.
  - Div by 0 with a=8'h2A -> result 16'hFFFF, remainder 8'h2A, divide_by_zero 1, latency 1.
REQ-035 Backpressure: hold out_ready = 0 for 5 cycles in DONE -> outputs stable and in_ready = 0; in_valid pulses during this time are ignored.
REQ-036 Assert rst 3 cycles into a WIDTH=16 div -> next cycle out_valid 0, in_ready 1, all outputs 0. A new add then completes normally.
